lcd_pwr_seq_ctrl: RTL
=====================

Name: lcd_pwr_seq_ctrl

Overview:
- Parametrised LCD panel power sequencer and successor to the fixed two-rail sequencer.
- Powers up NUM_RAILS supply rails in index order, checking power-good on each, then drives the panel reset pulse train and raises hs_start to release the DSI high-speed path.
- On enable deassert it runs an orderly reverse power-down; on a power-good loss or timeout it performs an immediate fault shutdown.
- Sits between board power rails and the DSI TX controller.

Parameters:
- NUM_RAILS, 2: number of supply rails, 1..8.
- TICK_DIV, 27000: clk cycles per 1 ms tick.
- MS_W, 10: width of the ms counter; all *_MS values must be < 2^MS_W.
- RAIL_DLY_MS, 1: dwell after enabling each rail.
- PG_TMO_MS, 20: power-good timeout per rail, measured from rail enable; must be >= RAIL_DLY_MS.
- RST_H1_MS, 260: first reset-high phase.
- RST_LO_MS, 6: reset-low pulse.
- RST_H2_MS, 6: reset-high settle before hs_start.
- HS_DLY_MS, 6: delay from end of the RST_H2 phase to hs_start.
- DN_DLY_MS, 1: dwell between rail disables on power-down.
- CHECK_PG, 1: 1 = monitor rail_pg; 0 = ignore rail_pg.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: level request; 1 = power up and run, 0 = power down.
- rail_pg, input, NUM_RAILS: per-rail power-good, already synchronised upstream.
- rail_en, output, NUM_RAILS: per-rail enable.
- lcd_rst, output, 1: panel reset, active low at the panel.
- hs_start, output, 1: DSI high-speed start.
- ready, output, 1: high in RUN only.
- busy, output, 1: high in any state other than IDLE, RUN or FAULT.
- fault, output, 1: sticky fault flag.
- state_o, output, 4: current state encoding, for debug.

Behaviour:
- All outputs are registered. On reset: rail_en=0, lcd_rst=0, hs_start=0, ready=0, busy=0, fault=0, state=IDLE, rail index k=0, prescaler=0, ms_cnt=0. Reset takes priority over everything else.
- Timebase:
  - Prescaler counts 0..TICK_DIV-1. tick = (prescaler==TICK_DIV-1).
  - ms_cnt increments on tick and saturates at all-ones.
  - Prescaler and ms_cnt clear on the cycle of every state transition.
- "Dwell D" means the exit condition is tick && ms_cnt==D-1, giving exactly D*TICK_DIV cycles in the state. D=0 means exit on the first cycle.
- States (encoding 0..9):
  - IDLE(0): all outputs 0. enable=1 -> RAIL_UP with k=0.
  - RAIL_UP(1): rail_en[k]=1 (earlier rails stay on).
    - Exit when the RAIL_DLY_MS dwell has elapsed AND (rail_pg[k]==1 or CHECK_PG==0).
    - If CHECK_PG==1 and rail_pg[k]==0 at the PG_TMO_MS dwell point -> FAULT.
    - On exit: if k<NUM_RAILS-1, increment k and re-enter RAIL_UP (counters clear); otherwise go to RST_H1.
  - RST_H1(2): lcd_rst=1; dwell RST_H1_MS -> RST_LO.
  - RST_LO(3): lcd_rst=0; dwell RST_LO_MS -> RST_H2.
  - RST_H2(4): lcd_rst=1; dwell RST_H2_MS -> HS_WAIT.
  - HS_WAIT(5): dwell HS_DLY_MS -> RUN.
  - RUN(6): hs_start=1, ready=1; the prescaler keeps running.
  - HS_OFF(7): hs_start=0 and ready=0 for one cycle, then lcd_rst=0 and -> RAIL_DN.
  - RAIL_DN(8): k indexes the highest enabled rail.
    - On entry, rail_en[k] is cleared.
    - After dwell DN_DLY_MS: if k==0 -> IDLE; else decrement k and stay in RAIL_DN.
  - FAULT(9): in the same transition cycle, rail_en, lcd_rst, hs_start and ready all go to 0 and fault goes to 1. Remains in FAULT while enable=1; enable=0 -> IDLE with fault cleared.
- enable=0 in any state from RAIL_UP through RUN -> HS_OFF. Power-down then covers only rails 0..k that are currently enabled. enable is ignored inside HS_OFF and RAIL_DN; the sequence always completes to IDLE, and re-power starts from IDLE if enable is still 1.
- CHECK_PG==1 and any enabled rail's pg==0 in states RST_H1..RUN -> FAULT.
- Simultaneous enable=0 and a pg fault in the same cycle: FAULT takes priority.
- ms_cnt saturation must never create a false exit.

Test Plan:
- Configuration: TICK_DIV=4, NUM_RAILS=2, RAIL_DLY_MS=2, RST_H1_MS=3, RST_LO_MS=1, RST_H2_MS=1, HS_DLY_MS=2, PG_TMO_MS=5, DN_DLY_MS=1, rail_pg tied high.
- Power-up: enable rises at cycle 0 -> rail_en=01 at cycle 2, rail_en=11 at cycle 10, lcd_rst 1 at 18, 0 at 30, 1 at 34, hs_start=1 and ready=1 at 46.
- Power-down from RUN: enable=0 -> hs_start=0 after 1 cycle, lcd_rst=0 the next cycle, rail_en 11 -> 01 -> 00 spaced 4 cycles apart, then IDLE with busy=0.
- PG timeout: rail_pg[1] held at 0 -> FAULT 20 cycles after rail_en[1] rises, rail_en=00, fault=1. fault holds while enable=1 and clears after enable=0.
- Abort mid power-up: enable=0 while in RAIL_UP with k=1 -> both rails disabled in reverse order, reaches IDLE, and the sequence restarts automatically if enable returns to 1.
- Run fault and reset: rail_pg[0] drops in RUN -> hs_start=0 and fault=1 next cycle. Synchronous reset asserted mid-RST_H1 -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/lcd_pwr_seq_ctrl_if.sv
// Control and status bundle between the LCD power sequencer, the board supply
// rails and the DSI TX controller.
interface lcd_pwr_seq_ctrl_if #(
  parameter int unsigned NUM_RAILS = 2
);
  logic                 enable;
  logic [NUM_RAILS-1:0] rail_pg;
  logic [NUM_RAILS-1:0] rail_en;
  logic                 lcd_rst;
  logic                 hs_start;
  logic                 ready;
  logic                 busy;
  logic                 fault;
  logic [3:0]           state_o;

  // Sequencer side: consumes the request and power-good, drives everything else.
  modport master (
    input  enable,
    input  rail_pg,
    output rail_en,
    output lcd_rst,
    output hs_start,
    output ready,
    output busy,
    output fault,
    output state_o
  );

  // Board / system side.
  modport slave (
    output enable,
    output rail_pg,
    input  rail_en,
    input  lcd_rst,
    input  hs_start,
    input  ready,
    input  busy,
    input  fault,
    input  state_o
  );
endinterface

// File: rtl/lcd_pwr_seq_ctrl.sv
// LCD panel power sequencer: staged rail bring-up with power-good checks, panel
// reset pulse train, DSI HS release, orderly reverse power-down and fault shutdown.
module lcd_pwr_seq_ctrl #(
  parameter int unsigned NUM_RAILS   = 2,
  parameter int unsigned TICK_DIV    = 27000,
  parameter int unsigned MS_W        = 10,
  parameter int unsigned RAIL_DLY_MS = 1,
  parameter int unsigned PG_TMO_MS   = 20,
  parameter int unsigned RST_H1_MS   = 260,
  parameter int unsigned RST_LO_MS   = 6,
  parameter int unsigned RST_H2_MS   = 6,
  parameter int unsigned HS_DLY_MS   = 6,
  parameter int unsigned DN_DLY_MS   = 1,
  parameter int unsigned CHECK_PG    = 1
) (
  input  logic               clk,
  input  logic               reset,
  lcd_pwr_seq_ctrl_if.master bus
);

  localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned K_W  = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;

  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);
  localparam logic [K_W-1:0]  K_LAST = K_W'(NUM_RAILS - 1);
  localparam logic [MS_W-1:0] MS_SAT = '1;
  localparam logic            PG_ON  = (CHECK_PG != 0);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RAIL_UP = 4'd1,
    ST_RST_H1  = 4'd2,
    ST_RST_LO  = 4'd3,
    ST_RST_H2  = 4'd4,
    ST_HS_WAIT = 4'd5,
    ST_RUN     = 4'd6,
    ST_HS_OFF  = 4'd7,
    ST_RAIL_DN = 4'd8,
    ST_FAULT   = 4'd9
  } state_e;

  state_e               state_q, state_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [PS_W-1:0]      ps_q;
  logic [MS_W-1:0]      ms_q;
  logic [NUM_RAILS-1:0] rail_en_q;
  logic                 lcd_rst_q;
  logic                 hs_start_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 fault_q;

  logic                 tick;
  logic                 xfer;
  logic                 pg_k;
  logic                 rail_dly_met;
  logic                 tmo_hit;
  logic                 run_pg_fault;
  logic                 phase_done;
  state_e               phase_next;
  logic [NUM_RAILS-1:0] k_onehot;

  // True on the last cycle of a D ms dwell; D=0 exits immediately.
  function automatic logic dwell_hit(input logic [MS_W-1:0] ms, input logic t,
                                     input int unsigned d);
    if (d == 0) return 1'b1;
    return t && (ms == MS_W'(d - 1));
  endfunction

  assign tick     = (ps_q == PS_MAX);
  assign pg_k     = bus.rail_pg[k_q];
  assign k_onehot = NUM_RAILS'(1) << k_d;
  assign tmo_hit  = dwell_hit(ms_q, tick, PG_TMO_MS);

  // The rail dwell is remembered past its tick so a late power-good still advances.
  assign rail_dly_met = dwell_hit(ms_q, tick, RAIL_DLY_MS) ||
                        (ms_q >= MS_W'(RAIL_DLY_MS));
  assign run_pg_fault = PG_ON && (|(rail_en_q & ~bus.rail_pg));

  // Dwell exit and successor for the timed reset/HS phases.
  always_comb begin
    phase_done = 1'b0;
    phase_next = state_q;
    unique case (state_q)
      ST_RST_H1:  begin phase_done = dwell_hit(ms_q, tick, RST_H1_MS); phase_next = ST_RST_LO;  end
      ST_RST_LO:  begin phase_done = dwell_hit(ms_q, tick, RST_LO_MS); phase_next = ST_RST_H2;  end
      ST_RST_H2:  begin phase_done = dwell_hit(ms_q, tick, RST_H2_MS); phase_next = ST_HS_WAIT; end
      ST_HS_WAIT: begin phase_done = dwell_hit(ms_q, tick, HS_DLY_MS); phase_next = ST_RUN;     end
      default:    begin phase_done = 1'b0;                              phase_next = state_q;    end
    endcase
  end

  // Next state, rail index and the transition strobe that clears the timebase.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    xfer    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d = ST_RAIL_UP;
          k_d     = '0;
          xfer    = 1'b1;
        end
      end
      ST_RAIL_UP: begin
        if (PG_ON && !pg_k && tmo_hit) begin
          state_d = ST_FAULT;
          xfer    = 1'b1;
        end else if (!bus.enable) begin
          state_d = ST_HS_OFF;
          xfer    = 1'b1;
        end else if (rail_dly_met && (pg_k || !PG_ON)) begin
          xfer = 1'b1;
          if (k_q == K_LAST) state_d = ST_RST_H1;
          else               k_d     = k_q + K_W'(1);
        end
      end
      ST_RST_H1, ST_RST_LO, ST_RST_H2, ST_HS_WAIT, ST_RUN: begin
        if (run_pg_fault) begin
          state_d = ST_FAULT;
          xfer    = 1'b1;
        end else if (!bus.enable) begin
          state_d = ST_HS_OFF;
          xfer    = 1'b1;
        end else if (phase_done) begin
          state_d = phase_next;
          xfer    = 1'b1;
        end
      end
      ST_HS_OFF: begin
        state_d = ST_RAIL_DN;
        xfer    = 1'b1;
      end
      ST_RAIL_DN: begin
        if (dwell_hit(ms_q, tick, DN_DLY_MS)) begin
          xfer = 1'b1;
          if (k_q == '0) state_d = ST_IDLE;
          else           k_d     = k_q - K_W'(1);
        end
      end
      ST_FAULT: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
          k_d     = '0;
          xfer    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = '0;
        xfer    = 1'b1;
      end
    endcase
  end

  // State, timebase and outputs, all registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      ps_q       <= '0;
      ms_q       <= '0;
      rail_en_q  <= '0;
      lcd_rst_q  <= 1'b0;
      hs_start_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;

      if (xfer) begin
        ps_q <= '0;
        ms_q <= '0;
      end else begin
        ps_q <= tick ? '0 : ps_q + PS_W'(1);
        if (tick && (ms_q != MS_SAT)) ms_q <= ms_q + MS_W'(1);
      end

      // Rails accumulate on the way up and drop one per RAIL_DN step on the way down.
      unique case (state_d)
        ST_RAIL_UP:         rail_en_q <= rail_en_q | k_onehot;
        ST_RAIL_DN:         if (xfer) rail_en_q <= rail_en_q & ~k_onehot;
        ST_IDLE, ST_FAULT:  rail_en_q <= '0;
        default:            rail_en_q <= rail_en_q;
      endcase

      // Panel reset is held through HS_OFF so the DSI link drops first.
      unique case (state_d)
        ST_RST_H1, ST_RST_H2, ST_HS_WAIT, ST_RUN: lcd_rst_q <= 1'b1;
        ST_HS_OFF:                                lcd_rst_q <= lcd_rst_q;
        default:                                  lcd_rst_q <= 1'b0;
      endcase

      hs_start_q <= (state_d == ST_RUN);
      ready_q    <= (state_d == ST_RUN);
      busy_q     <= !((state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_FAULT));
      fault_q    <= (state_d == ST_FAULT);
    end
  end

  assign bus.rail_en  = rail_en_q;
  assign bus.lcd_rst  = lcd_rst_q;
  assign bus.hs_start = hs_start_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.fault    = fault_q;
  assign bus.state_o  = state_q;

endmodule
